// File: rtl/vrf_port_arbiter.sv
// rtl/vrf_port_arbiter.sv - two-requester arbiter in front of the single-port vector register file
//
// Port A (vector execution pipeline) has priority by default. Port B (vector load/store
// unit) is promoted to priority once it has been blocked for MAX_WAIT cycles. It drops
// back after its next grant. Each grant is exactly one SRAM read or masked write. Read data
// returns on the requester's response port two cycles after the request is accepted.
//
// Ports
//   clk, reset                    clock; asynchronous active-low reset
//   {a,b}_valid / {a,b}_ready     request handshake; ready is the combinational grant
//   {a,b}_we, _addr, _mask, _wdata
//                                 request fields; mask bit order is the same as sram_mask
//   {a,b}_rsp_valid, _rsp_data    read response; one-cycle pulse; data holds between pulses
//   sram_en, sram_we, sram_addr,
//   sram_mask, sram_wdata         Vector_rf request side, driven from the granted port
//   sram_rdata                    Vector_rf read data, valid the cycle after a read issue
module vrf_port_arbiter #(
   parameter  int NUM_ELEMS           = 8,
   parameter  int ELEM_SIZE           = 16,
   parameter  int ENABLES_PER_ELEMENT = 4,
   parameter  int VRF_SIZE            = 32,
   parameter  int MAX_WAIT            = 4,
   localparam int W                   = NUM_ELEMS * ELEM_SIZE,
   localparam int M                   = NUM_ELEMS * ENABLES_PER_ELEMENT,
   localparam int AW                  = $clog2(VRF_SIZE)
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          a_valid,
   output logic          a_ready,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [M-1:0]  a_mask,
   input  logic [W-1:0]  a_wdata,
   output logic          a_rsp_valid,
   output logic [W-1:0]  a_rsp_data,

   input  logic          b_valid,
   output logic          b_ready,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [M-1:0]  b_mask,
   input  logic [W-1:0]  b_wdata,
   output logic          b_rsp_valid,
   output logic [W-1:0]  b_rsp_data,

   output logic          sram_en,
   output logic          sram_we,
   output logic [AW-1:0] sram_addr,
   output logic [M-1:0]  sram_mask,
   output logic [W-1:0]  sram_wdata,
   input  logic [W-1:0]  sram_rdata
);

   // MAX_WAIT is legal up to 255, so an 8-bit counter always holds it.
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_t;

   prio_t       state;
   prio_t       state_nxt;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_cnt_nxt;
   logic        grant_a;
   logic        grant_b;
   logic        rd_issue;

   // Read tag pipe. Stage 1 marks a read that was issued at the last edge; its data is on
   // sram_rdata now. The rsp_valid registers themselves act as stage 2.
   logic        tag_v;
   logic        tag_b;

   // ------------------------------------------------------------------
   // Priority FSM and starvation counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= PRIO_A;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      grant_a      = 1'b0;
      grant_b      = 1'b0;
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;

      // Grants are held off while reset is asserted. This keeps ready and sram_en low
      // throughout reset, not just at the first edge after it.
      if (reset) begin
         if (state == PRIO_A) begin
            grant_a = a_valid;
            grant_b = b_valid & ~a_valid;
         end else begin
            grant_b = b_valid;
            grant_a = a_valid & ~b_valid;
         end
      end

      if (grant_b) begin
         wait_cnt_nxt = '0;
      end else if (b_valid && (wait_cnt != MAX_WAIT_C)) begin
         wait_cnt_nxt = wait_cnt + 8'd1;
      end

      // Promotion is decided on the count as it lands on MAX_WAIT. This means B wins on the
      // cycle after its MAX_WAIT-th blocked cycle, so it is blocked at most MAX_WAIT
      // cycles in a row.
      case (state)
         PRIO_A:  if (wait_cnt_nxt == MAX_WAIT_C) state_nxt = PRIO_B;
         PRIO_B:  if (grant_b)                    state_nxt = PRIO_A;
         default: state_nxt = PRIO_A;
      endcase
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   // ------------------------------------------------------------------
   // SRAM request mux
   // ------------------------------------------------------------------
   always_comb begin
      sram_en    = grant_a | grant_b;
      sram_we    = 1'b0;
      if (grant_a) begin
         sram_we = a_we;
      end else if (grant_b) begin
         sram_we = b_we;
      end
      // Address, mask and data are only meaningful while sram_en is high. When idle they
      // follow port A.
      sram_addr  = grant_b ? b_addr  : a_addr;
      sram_mask  = grant_b ? b_mask  : a_mask;
      sram_wdata = grant_b ? b_wdata : a_wdata;
   end

   assign rd_issue = sram_en & ~sram_we;

   // ------------------------------------------------------------------
   // Read response pipeline
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_v       <= 1'b0;
         tag_b       <= 1'b0;
         a_rsp_valid <= 1'b0;
         b_rsp_valid <= 1'b0;
         a_rsp_data  <= '0;
         b_rsp_data  <= '0;
      end else begin
         tag_v       <= rd_issue;
         tag_b       <= grant_b;
         a_rsp_valid <= tag_v & ~tag_b;
         b_rsp_valid <= tag_v &  tag_b;
         if (tag_v && !tag_b) begin
            a_rsp_data <= sram_rdata;
         end
         if (tag_v && tag_b) begin
            b_rsp_data <= sram_rdata;
         end
      end
   end

endmodule
